// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and default operand width for the restoring divider
package div_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, DONE = 2'd2} state_t;
   localparam int DIV_W = 8;
endpackage

// File: rtl/restoring_div_seq_if.sv
// restoring_div_seq_if: start/operand request and result/status bundle of the divider
interface restoring_div_seq_if #(parameter int N = div_pkg::DIV_W);
   logic         start;
   logic [N-1:0] dividend;
   logic [N-1:0] divisor;
   logic         busy;
   logic         done;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         div0;
   modport master (output start, dividend, divisor, input busy, done, quotient, remainder, div0);
   modport slave (input start, dividend, divisor, output busy, done, quotient, remainder, div0);
endinterface

// File: rtl/div_aq_shift.sv
// div_aq_shift: A/Q shift-subtract-restore register pair; A's top bit is always zero
// between iterations (A < M), so only N bits are stored and the N+1-bit width lives
// in the shifted/subtracted working values.
module div_aq_shift #(parameter int N = 8) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         shift,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] m,
   output logic         neg,
   output logic [N-1:0] r_nxt,
   output logic [N-1:0] q_nxt
);
   logic [N-1:0] a, q;
   logic [N:0]   a_sh, t;
   // one iteration: shift {A,Q} left, trial-subtract M, restore when negative
   always_comb begin
      a_sh  = {a, q[N-1]};
      t     = a_sh - {1'b0, m};
      neg   = t[N];
      r_nxt = neg ? a_sh[N-1:0] : t[N-1:0];
      q_nxt = {q[N-2:0], ~neg};
   end
   // load operands on accepted start, otherwise advance one iteration when enabled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a <= '0;
         q <= '0;
      end else if (load) begin
         a <= '0;
         q <= dividend;
      end else if (shift) begin
         a <= r_nxt;
         q <= q_nxt;
      end
   end
endmodule

// File: rtl/restoring_div_seq.sv
// restoring_div_seq: iterative unsigned restoring divider sequencer; DIV_ZERO_EARLY_EN
// enables the divide-by-zero shortcut and the div0 flag.
module restoring_div_seq import div_pkg::*; #(parameter int N = DIV_W) (
   input logic               clk,
   input logic               rst_n,
   restoring_div_seq_if.slave bus
);
   localparam int CNT_W = $clog2(N + 1);
   state_t           state, state_nxt;
   logic [CNT_W-1:0] count;
   logic [N-1:0]     m, r_nxt, q_nxt;
   logic             neg, load, last, div0_early;
   assign load = state == IDLE && bus.start;
   assign last = state == ITER && count == CNT_W'(1);
`ifdef DIV_ZERO_EARLY_EN
   assign div0_early = load && bus.divisor == '0;
`else
   assign div0_early = 1'b0;
`endif
   div_aq_shift #(.N(N)) u_aq (
      .clk(clk), .rst_n(rst_n), .load(load), .shift(state == ITER),
      .dividend(bus.dividend), .m(m), .neg(neg), .r_nxt(r_nxt), .q_nxt(q_nxt)
   );
   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   end
   // next state: zero divisor may bypass the iterations when the shortcut is built in
   always_comb begin
      state_nxt = state == IDLE ? (bus.start ? (div0_early ? DONE : ITER) : IDLE) :
                  state == ITER ? (last ? DONE : ITER) : IDLE;
   end
   // status outputs decoded from state
   always_comb begin
      bus.busy = state != IDLE;
      bus.done = state == DONE;
   end
   // iteration counter and divisor register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
         m     <= '0;
      end else if (load) begin
         count <= CNT_W'(N);
         m     <= bus.divisor;
      end else if (state == ITER) begin
         count <= count - 1'b1;
      end
   end
   // results captured on entry to DONE and held until the next completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus.quotient  <= '0;
         bus.remainder <= '0;
      end else if (div0_early) begin
         bus.quotient  <= '1;
         bus.remainder <= bus.dividend;
      end else if (last) begin
         bus.quotient  <= q_nxt;
         bus.remainder <= r_nxt;
      end
   end
`ifdef DIV_ZERO_EARLY_EN
   // divide-by-zero flag, refreshed on every accepted start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) bus.div0 <= 1'b0;
      else if (load) bus.div0 <= div0_early;
   end
`else
   assign bus.div0 = 1'b0;
`endif
endmodule

// File: tb/tb_restoring_div_seq.sv
// tb_restoring_div_seq: directed and random checks of restoring_div_seq against plain arithmetic
module tb_restoring_div_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   t0 = 0;
   int   total = 0;
   int   fails = 0;
`ifdef DIV_ZERO_EARLY_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif
   restoring_div_seq_if #(.N(8)) bus ();
   restoring_div_seq #(.N(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model(input int dd, input int dv, output int q, output int r, output int lat);
      q   = dv == 0 ? 255 : dd / dv;
      r   = dv == 0 ? dd : dd % dv;
      lat = (EARLY && dv == 0) ? 1 : 9;
   endfunction

   task automatic start_op(input int dd, input int dv);
      @(negedge clk);
      bus.start    = 1'b1;
      bus.dividend = 8'(dd);
      bus.divisor  = 8'(dv);
      @(posedge clk);
      #1;
      t0 = cyc;
      bus.start = 1'b0;
   endtask

   task automatic wait_done(output int lat);
      lat = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (bus.done) begin
            lat = cyc - t0 + 1;
            return;
         end
         chk("busy_during_op", int'(bus.busy), 1);
      end
   endtask

   task automatic check_result(input int dd, input int dv, input int lat);
      int q, r, l;
      model(dd, dv, q, r, l);
      chk("latency", lat, l);
      chk("quotient", int'(bus.quotient), q);
      chk("remainder", int'(bus.remainder), r);
      chk("div0", int'(bus.div0), int'(EARLY && dv == 0));
      chk("busy_at_done", int'(bus.busy), 1);
   endtask

   task automatic run(input int dd, input int dv);
      int lat;
      start_op(dd, dv);
      wait_done(lat);
      check_result(dd, dv, lat);
      @(negedge clk);
      chk("done_strobe_one_cycle", int'(bus.done), 0);
      chk("idle_after_done", int'(bus.busy), 0);
   endtask

   task automatic no_done_for(input int n);
      int hits = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (bus.done) hits++;
      end
      chk("no_extra_done", hits, 0);
   endtask

   initial begin
      int lat;
      bus.start = 1'b0;
      bus.dividend = '0;
      bus.divisor = '0;
      #3;
      chk("rst_busy", int'(bus.busy), 0);
      chk("rst_done", int'(bus.done), 0);
      chk("rst_quotient", int'(bus.quotient), 0);
      chk("rst_remainder", int'(bus.remainder), 0);
      chk("rst_div0", int'(bus.div0), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run(100, 7);
      run(255, 1);
      run(0, 5);
      run(7, 200);
      run(13, 0);
      run(255, 255);
      // starts during ITER and during DONE must be ignored
      start_op(100, 7);
      repeat (3) @(posedge clk);
      #1;
      bus.start = 1'b1;
      bus.dividend = 8'd55;
      bus.divisor = 8'd3;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(lat);
      check_result(100, 7, lat);
      bus.start = 1'b1;
      bus.dividend = 8'd9;
      bus.divisor = 8'd2;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      no_done_for(12);
      chk("ignored_quotient", int'(bus.quotient), 14);
      chk("ignored_remainder", int'(bus.remainder), 2);
      chk("ignored_busy", int'(bus.busy), 0);
      // async reset mid-operation (after a div0 result so every output is nonzero first)
      run(13, 0);
      start_op(200, 3);
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst_busy", int'(bus.busy), 0);
      chk("arst_done", int'(bus.done), 0);
      chk("arst_quotient", int'(bus.quotient), 0);
      chk("arst_remainder", int'(bus.remainder), 0);
      chk("arst_div0", int'(bus.div0), 0);
      @(negedge clk);
      rst_n = 1'b1;
      no_done_for(12);
      run(200, 3);
      // back-to-back start in the IDLE cycle right after DONE
      start_op(100, 7);
      wait_done(lat);
      check_result(100, 7, lat);
      start_op(250, 16);
      chk("held_quotient", int'(bus.quotient), 14);
      chk("held_remainder", int'(bus.remainder), 2);
      wait_done(lat);
      check_result(250, 16, lat);
      for (int k = 0; k < 20; k++)
         run(int'($urandom_range(0, 255)), (k % 5 == 0) ? 0 : int'($urandom_range(1, 255)));
      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end
endmodule
